// File: rtl/hazard_ctrl_pkg.sv
// Shared types and encodings for the ID/EX/WB hazard controller.
// FSM states, forwarding selects and the tracked-slot bundle.
package hazard_ctrl_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_EX = 2'b01;
   localparam logic [1:0] FWD_WB = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_MEM_WAIT,
      ST_FLUSH
   } state_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] waddr;
      logic                  wren;
      logic                  is_load;
   } slot_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forwarding select and load-use detect for the ID instruction.
// Purely combinational; compares ID sources against the EX and WB slots.
module hazard_fwd_unit
   import hazard_ctrl_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   input  logic                  rs1_used,
   input  logic                  rs2_used,
   input  slot_t                 ex_slot,
   input  slot_t                 wb_slot,
   output logic [1:0]            sel1,
   output logic [1:0]            sel2,
   output logic                  load_use
);

   function automatic logic hit(
      input logic [REG_ADDR_W-1:0] addr,
      input logic                  used,
      input slot_t                 s
   );
      return used && (addr != '0) && s.wren && (s.waddr == addr);
   endfunction

   logic ex1, ex2, wb1, wb2;

   assign ex1 = hit(rs1, rs1_used, ex_slot);
   assign ex2 = hit(rs2, rs2_used, ex_slot);
   assign wb1 = hit(rs1, rs1_used, wb_slot);
   assign wb2 = hit(rs2, rs2_used, wb_slot);

   // the younger producer in EX wins over WB
   assign sel1 = ex1 ? FWD_EX : (wb1 ? FWD_WB : FWD_RF);
   assign sel2 = ex2 ? FWD_EX : (wb2 ? FWD_WB : FWD_RF);

   assign load_use = (ex1 || ex2) && ex_slot.is_load;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, stall and flush controller for the ID/EX/WB pipeline.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int BRANCH_PENALTY = 2,
   parameter int MEM_TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] rs1_ID,
   input  logic [REG_ADDR_W-1:0] rs2_ID,
   input  logic                  rs1_used_ID,
   input  logic                  rs2_used_ID,
   input  logic [REG_ADDR_W-1:0] WAddr_ID,
   input  logic                  WrEn_RF_ID,
   input  logic                  is_load_ID,
   input  logic                  branch_taken_EX,
   input  logic                  dmem_req_EX,
   input  logic                  dmem_ready,
   output logic [1:0]            ALU_hazmux1_sel_ID,
   output logic [1:0]            ALU_hazmux2_sel_ID,
   output logic                  stall_IF,
   output logic                  stall_ID,
   output logic                  stall_EX,
   output logic                  bubble_EX,
   output logic                  flush_ID,
   output logic                  mem_timeout,
   output logic [31:0]           load_stall_cnt,
   output logic [31:0]           mem_stall_cnt,
   output logic [31:0]           flush_cnt
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);
   localparam logic [2:0] BP_M1 = 3'(BRANCH_PENALTY - 1);

   state_t        state_q, state_d;
   slot_t         ex_q, wb_q;
   logic [2:0]    fcnt_q, fcnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          load_use;
   logic          s_if, s_id, s_ex, bub, fl, ld_stall;

   hazard_fwd_unit u_fwd (
      .rs1      (rs1_ID),
      .rs2      (rs2_ID),
      .rs1_used (rs1_used_ID),
      .rs2_used (rs2_used_ID),
      .ex_slot  (ex_q),
      .wb_slot  (wb_q),
      .sel1     (ALU_hazmux1_sel_ID),
      .sel2     (ALU_hazmux2_sel_ID),
      .load_use (load_use)
   );

   always_comb begin
      state_d  = state_q;
      fcnt_d   = fcnt_q;
      tcnt_d   = tcnt_q;
      s_if     = 1'b0;
      s_id     = 1'b0;
      s_ex     = 1'b0;
      bub      = 1'b0;
      fl       = 1'b0;
      ld_stall = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (dmem_req_EX && !dmem_ready) begin
               s_if    = 1'b1;
               s_id    = 1'b1;
               s_ex    = 1'b1;
               tcnt_d  = TW'(1);
               state_d = ST_MEM_WAIT;
            end else if (branch_taken_EX) begin
               fl  = 1'b1;
               bub = 1'b1;
               if (BRANCH_PENALTY > 1) begin
                  fcnt_d  = BP_M1;
                  state_d = ST_FLUSH;
               end
            end else if (load_use) begin
               s_if     = 1'b1;
               s_id     = 1'b1;
               bub      = 1'b1;
               ld_stall = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (dmem_ready) begin
               state_d = ST_RUN;
            end else begin
               s_if = 1'b1;
               s_id = 1'b1;
               s_ex = 1'b1;
               if (tcnt_q != TMAX) tcnt_d = tcnt_q + TW'(1);
            end
         end
         ST_FLUSH: begin
            // load-use is ignored: the ID instruction is being killed
            if (fcnt_q != 3'd0) begin
               fl     = 1'b1;
               fcnt_d = fcnt_q - 3'd1;
            end
            if (fcnt_q <= 3'd1) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // strobes are forced low while reset is held, whatever the inputs do
   assign stall_IF  = reset & s_if;
   assign stall_ID  = reset & s_id;
   assign stall_EX  = reset & s_ex;
   assign bubble_EX = reset & bub;
   assign flush_ID  = reset & fl;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         fcnt_q      <= '0;
         tcnt_q      <= '0;
         mem_timeout <= 1'b0;
         ex_q        <= '0;
         wb_q        <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         tcnt_q  <= tcnt_d;
         if (s_ex && (tcnt_d == TMAX)) mem_timeout <= 1'b1;
         if (!s_ex) begin
            wb_q       <= ex_q;
            ex_q.waddr <= WAddr_ID;
            ex_q.wren  <= WrEn_RF_ID & ~(bub | fl);
            ex_q.is_load <= is_load_ID;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] ld_q, ms_q, fc_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ld_q <= '0;
         ms_q <= '0;
         fc_q <= '0;
      end else begin
         if (ld_stall) ld_q <= sat_inc(ld_q);
         if (s_ex)     ms_q <= sat_inc(ms_q);
         if (fl)       fc_q <= sat_inc(fc_q);
      end
   end

   assign load_stall_cnt = ld_q;
   assign mem_stall_cnt  = ms_q;
   assign flush_cnt      = fc_q;
`else
   logic unused_perf;
   assign unused_perf    = ld_stall;
   assign load_stall_cnt = '0;
   assign mem_stall_cnt  = '0;
   assign flush_cnt      = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl.
// Covers forwarding, load-use, mem wait/timeout, branch flush, async reset.
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs1_ID, rs2_ID, WAddr_ID;
   logic        rs1_used_ID, rs2_used_ID;
   logic        WrEn_RF_ID, is_load_ID;
   logic        branch_taken_EX, dmem_req_EX, dmem_ready;
   logic [1:0]  ALU_hazmux1_sel_ID, ALU_hazmux2_sel_ID;
   logic        stall_IF, stall_ID, stall_EX, bubble_EX, flush_ID;
   logic        mem_timeout;
   logic [31:0] load_stall_cnt, mem_stall_cnt, flush_cnt;

   int n_vec = 0;
   int n_err = 0;

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [31:0] EXP_LD = 32'd1;
   localparam logic [31:0] EXP_MS = 32'd3;
   localparam logic [31:0] EXP_FL = 32'd2;
`else
   localparam logic [31:0] EXP_LD = 32'd0;
   localparam logic [31:0] EXP_MS = 32'd0;
   localparam logic [31:0] EXP_FL = 32'd0;
`endif

   // {stall_IF, stall_ID, stall_EX, bubble_EX, flush_ID}
   wire [4:0] strobes = {stall_IF, stall_ID, stall_EX, bubble_EX, flush_ID};

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .BRANCH_PENALTY (2),
      .MEM_TIMEOUT    (16)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .rs1_ID             (rs1_ID),
      .rs2_ID             (rs2_ID),
      .rs1_used_ID        (rs1_used_ID),
      .rs2_used_ID        (rs2_used_ID),
      .WAddr_ID           (WAddr_ID),
      .WrEn_RF_ID         (WrEn_RF_ID),
      .is_load_ID         (is_load_ID),
      .branch_taken_EX    (branch_taken_EX),
      .dmem_req_EX        (dmem_req_EX),
      .dmem_ready         (dmem_ready),
      .ALU_hazmux1_sel_ID (ALU_hazmux1_sel_ID),
      .ALU_hazmux2_sel_ID (ALU_hazmux2_sel_ID),
      .stall_IF           (stall_IF),
      .stall_ID           (stall_ID),
      .stall_EX           (stall_EX),
      .bubble_EX          (bubble_EX),
      .flush_ID           (flush_ID),
      .mem_timeout        (mem_timeout),
      .load_stall_cnt     (load_stall_cnt),
      .mem_stall_cnt      (mem_stall_cnt),
      .flush_cnt          (flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic id(input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2,
                     input logic [4:0] wa, input logic we,
                     input logic ld);
      rs1_ID      = r1;
      rs1_used_ID = u1;
      rs2_ID      = r2;
      rs2_used_ID = u2;
      WAddr_ID    = wa;
      WrEn_RF_ID  = we;
      is_load_ID  = ld;
   endtask

   initial begin
      reset           = 1'b0;
      branch_taken_EX = 1'b0;
      dmem_req_EX     = 1'b0;
      dmem_ready      = 1'b0;
      id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #2;
      chk("rst_init_strb", 32'(strobes), 32'd0);
      chk("rst_init_sel1", 32'(ALU_hazmux1_sel_ID), 32'd0);
      chk("rst_init_to", 32'(mem_timeout), 32'd0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      tick();

      // forwarding
      id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      tick();
      id(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      settle();
      chk("fwd_ex", 32'(ALU_hazmux1_sel_ID), 32'd1);
      tick();
      id(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      settle();
      chk("fwd_prio", 32'(ALU_hazmux1_sel_ID), 32'd1);
      tick();
      id(5'd5, 1'b1, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0);
      settle();
      chk("fwd_wb", 32'(ALU_hazmux1_sel_ID), 32'd2);
      chk("fwd_x0", 32'(ALU_hazmux2_sel_ID), 32'd0);
      tick();
      id(5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
      settle();
      chk("fwd_nowren", 32'(ALU_hazmux2_sel_ID), 32'd0);
      chk("fwd_strb", 32'(strobes), 32'd0);
      tick();
      id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
      tick();

      // load-use
      id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
      settle();
      chk("lu_pre", 32'(strobes), 32'd0);
      tick();
      id(5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
      settle();
      chk("lu_stall", 32'(strobes), 32'b11010);
      tick();
      settle();
      chk("lu_release", 32'(strobes), 32'd0);
      chk("lu_fwd", 32'(ALU_hazmux2_sel_ID), 32'd2);
      tick();

      // data-cache wait, 3 cycles
      id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      dmem_req_EX = 1'b1;
      dmem_ready  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("mw_stall", 32'(strobes), 32'b11100);
         tick();
      end
      dmem_ready = 1'b1;
      settle();
      chk("mw_ready", 32'(strobes), 32'd0);
      tick();
      dmem_req_EX = 1'b0;
      dmem_ready  = 1'b0;
      settle();
      chk("mw_after", 32'(strobes), 32'd0);
      chk("mw_to", 32'(mem_timeout), 32'd0);
      tick();

      // taken branch, then killed load-use pattern
      branch_taken_EX = 1'b1;
      id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
      settle();
      chk("br_strb", 32'(strobes), 32'b00011);
      tick();
      branch_taken_EX = 1'b0;
      id(5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
      settle();
      chk("fl_strb", 32'(strobes), 32'b00001);
      chk("fl_fwd", 32'(ALU_hazmux1_sel_ID), 32'd0);
      tick();
      id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      settle();
      chk("fl_done", 32'(strobes), 32'd0);
      chk("cnt_load", load_stall_cnt, EXP_LD);
      chk("cnt_mem", mem_stall_cnt, EXP_MS);
      chk("cnt_flush", flush_cnt, EXP_FL);
      tick();

      // long wait -> timeout
      id(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
      tick();
      id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      dmem_req_EX = 1'b1;
      dmem_ready  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i == 15) begin
            settle();
            chk("to_pre", 32'(mem_timeout), 32'd0);
         end
         tick();
      end
      settle();
      chk("to_set", 32'(mem_timeout), 32'd1);
      chk("to_wait", 32'(strobes), 32'b11100);
      tick();
      settle();
      chk("to_sticky", 32'(mem_timeout), 32'd1);

      // asynchronous reset mid-wait
      #2 reset = 1'b0;
      #1;
      chk("arst_strb", 32'(strobes), 32'd0);
      chk("arst_to", 32'(mem_timeout), 32'd0);
      id(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      chk("arst_fwd", 32'(ALU_hazmux1_sel_ID), 32'd0);
      @(posedge clk);
      #2;
      dmem_req_EX = 1'b0;
      reset       = 1'b1;
      settle();
      chk("post_rst_strb", 32'(strobes), 32'd0);
      chk("post_rst_fwd", 32'(ALU_hazmux1_sel_ID), 32'd0);
      chk("post_rst_ld", load_stall_cnt, 32'd0);
      chk("post_rst_ms", mem_stall_cnt, 32'd0);
      chk("post_rst_fl", flush_cnt, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
